// File: rtl/hilo_unit_if.sv
// Host and multiplier signal bundle for hilo_unit.
// The slave modport is the unit's view; the master modport is the driver's view.
interface hilo_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic        mul_en;
  logic [31:0] prod;
  logic        rd_req;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        stall;

  modport slave (
    input  start, op, a, b, prod, rd_req, rd_sel,
    output mul_x, mul_y, mul_en, rd_data, rd_valid, busy, stall
  );

  modport master (
    output start, op, a, b, prod, rd_req, rd_sel,
    input  mul_x, mul_y, mul_en, rd_data, rd_valid, busy, stall
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit fronting an external fixed-latency multiplier.
// Optional macro HILO_MADD_EN makes op 11 accumulate into {HI,LO}; otherwise op 11 is a plain MULT.
//
// state | meaning
// IDLE  | accepting ops and reads
// WAIT  | multiplier settling, counter runs down from LAT-1
// WRITE | product (or sum) written to {HI,LO}
module hilo_unit #(
  parameter int unsigned LAT = 2
) (
  input logic       clk,
  input logic       rst,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] hi_q, lo_q;
  logic [15:0] mul_x_q, mul_y_q;
  logic        mul_en_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        busy;
  logic        rd_take;
  logic        acc_mul, acc_mthi, acc_mtlo, do_write;
  logic [31:0] wr_val;

  always_comb begin
    state_d  = state_q;
    acc_mul  = 1'b0;
    acc_mthi = 1'b0;
    acc_mtlo = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b01:   acc_mthi = 1'b1;
            2'b10:   acc_mtlo = 1'b1;
            default: begin
              acc_mul = 1'b1;
              state_d = WAIT;
            end
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = WRITE;
      end
      WRITE: begin
        do_write = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HILO_MADD_EN
  logic madd_q;

  always_ff @(posedge clk) begin
    if (rst)          madd_q <= 1'b0;
    else if (acc_mul) madd_q <= (bus.op == 2'b11);
  end

  assign wr_val = madd_q ? ({hi_q, lo_q} + bus.prod) : bus.prod;
`else
  assign wr_val = bus.prod;
`endif

  assign busy    = (state_q != IDLE);
  assign rd_take = bus.rd_req & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      hi_q       <= 16'd0;
      lo_q       <= 16'd0;
      mul_x_q    <= 16'd0;
      mul_y_q    <= 16'd0;
      mul_en_q   <= 1'b0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_mul) begin
        mul_x_q  <= bus.a;
        mul_y_q  <= bus.b;
        mul_en_q <= 1'b1;
        cnt_q    <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_write) begin
        {hi_q, lo_q} <= wr_val;
        mul_en_q     <= 1'b0;
      end
      if (acc_mthi) hi_q <= bus.a;
      if (acc_mtlo) lo_q <= bus.a;
      // Read samples pre-edge HI/LO, so a same-edge MTHI/MTLO is not seen
      rd_valid_q <= rd_take;
      if (rd_take) rd_data_q <= bus.rd_sel ? hi_q : lo_q;
    end
  end

  assign bus.mul_x    = mul_x_q;
  assign bus.mul_y    = mul_y_q;
  assign bus.mul_en   = mul_en_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;
  assign bus.stall    = bus.rd_req & busy;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed cases plus a randomized op mix against a transaction-level model.
module tb_hilo_unit;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hilo_unit_if bus();

  hilo_unit #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Multiplier stand-in: product is garbage until LAT edges after mul_en rose
  int settle = 0;
  logic signed [31:0] px, py;
  always @(posedge clk) begin
    if (!bus.mul_en) settle <= 0;
    else             settle <= settle + 1;
  end
  assign px = $signed(bus.mul_x);
  assign py = $signed(bus.mul_y);
  assign bus.prod = (settle >= LAT) ? (px * py) : 32'hDEAD_BEEF;

`ifdef HILO_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic [31:0] m_hilo;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mt(input bit hi, input logic [15:0] v);
    bus.start = 1'b1;
    bus.op    = hi ? 2'b01 : 2'b10;
    bus.a     = v;
    tick();
    bus.start = 1'b0;
    check("mt_busy", 32'(bus.busy), 32'd0);
    if (hi) m_hilo[31:16] = v;
    else    m_hilo[15:0]  = v;
  endtask

  task automatic do_read(input bit sel);
    logic [15:0] exp;
    exp = sel ? m_hilo[31:16] : m_hilo[15:0];
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
    #1;
    check("rd_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.rd_req = 1'b0;
    check("rd_valid", 32'(bus.rd_valid), 32'd1);
    check(sel ? "rd_hi" : "rd_lo", 32'(bus.rd_data), 32'(exp));
    tick();
    check("rd_pulse", 32'(bus.rd_valid), 32'd0);
  endtask

  // rmode: 0 no read, 1 read on the start edge, 2 read held while busy
  task automatic do_mul(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int rmode, input bit sel, input bit noise);
    logic signed [31:0] sa, sb;
    logic [31:0] p, exp_new;
    logic [31:0] pre;
    int bcnt;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    pre = m_hilo;
    exp_new = (MADD && op == 2'b11) ? (m_hilo + p) : p;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (rmode == 1) begin
      bus.rd_req = 1'b1;
      bus.rd_sel = sel;
    end
    tick();
    bus.start = 1'b0;
    check("acc_mul_x", 32'(bus.mul_x), 32'(a));
    check("acc_mul_y", 32'(bus.mul_y), 32'(b));
    check("acc_mul_en", 32'(bus.mul_en), 32'd1);
    if (rmode == 1) begin
      bus.rd_req = 1'b0;
      check("sim_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("sim_rd_data", 32'(bus.rd_data), 32'(sel ? pre[31:16] : pre[15:0]));
    end
    bcnt = 0;
    while (bus.busy && bcnt < 40) begin
      bcnt++;
      check("busy_mul_en", 32'(bus.mul_en), 32'd1);
      if (rmode == 2) begin
        bus.rd_req = 1'b1;
        bus.rd_sel = sel;
        #1;
        check("busy_stall", 32'(bus.stall), 32'd1);
        if (bcnt > 1) check("busy_rd_valid", 32'(bus.rd_valid), 32'd0);
      end
      if (noise) begin
        bus.start = $urandom_range(0, 1);
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
      end
      tick();
    end
    bus.start = 1'b0;
    check("busy_cycles", 32'(bcnt), 32'(LAT + 1));
    check("done_mul_en", 32'(bus.mul_en), 32'd0);
    check("hold_mul_x", 32'(bus.mul_x), 32'(a));
    check("hold_mul_y", 32'(bus.mul_y), 32'(b));
    m_hilo = exp_new;
    if (rmode == 2) begin
      check("rel_stall", 32'(bus.stall), 32'd0);
      tick();
      bus.rd_req = 1'b0;
      check("rel_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("rel_rd_data", 32'(bus.rd_data), 32'(sel ? m_hilo[31:16] : m_hilo[15:0]));
    end
    do_read(1'b1);
    do_read(1'b0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = 16'd0;
    bus.b      = 16'd0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    m_hilo     = 32'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_en", 32'(bus.mul_en), 32'd0);
    check("rst_mul_x", 32'(bus.mul_x), 32'd0);
    check("rst_mul_y", 32'(bus.mul_y), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);

    do_mul(2'b00, 16'd3, -16'sd5, 0, 1'b0, 1'b0);
    do_mt(1'b1, 16'h1234);
    do_mt(1'b0, 16'h5678);
    do_read(1'b1);
    do_read(1'b0);
    do_mul(2'b00, 16'd2, 16'd3, 2, 1'b0, 1'b0);
    do_mt(1'b1, 16'h0000);
    do_mt(1'b0, 16'h0010);
    do_mul(2'b11, 16'd4, 16'd4, 0, 1'b0, 1'b0);
    do_mul(2'b00, 16'h8000, 16'h8000, 0, 1'b0, 1'b1);
    do_mul(2'b11, 16'hFFFF, 16'h0001, 1, 1'b1, 1'b1);

    // Reset mid-multiply: nothing of the aborted op may land
    do_mt(1'b1, 16'hAAAA);
    do_mt(1'b0, 16'h5555);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 16'd7;
    bus.b     = 16'd7;
    tick();
    bus.start = 1'b0;
    tick();
    check("abort_in_wait", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hilo = 32'd0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_mul_en", 32'(bus.mul_en), 32'd0);
    repeat (LAT + 3) tick();
    check("abort_late_busy", 32'(bus.busy), 32'd0);
    do_read(1'b1);
    do_read(1'b0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0: do_mt(1'b1, 16'($urandom));
        1: do_mt(1'b0, 16'($urandom));
        5: do_read(1'($urandom_range(0, 1)));
        default: do_mul($urandom_range(0, 1) ? 2'b11 : 2'b00, 16'($urandom), 16'($urandom),
                        $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: LAT, default 2, number of cycles allowed for the external Booth multiplier product to settle (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  issue a HI/LO operation selected by op.
REQ-005 op  input  2  operation: 00 MULT, 01 MTHI, 10 MTLO, 11 MADD.
REQ-006 a  input  16  signed operand A; also write data for MTHI/MTLO.
REQ-007 b  input  16  signed operand B.
REQ-008 mul_x  output  16  registered operand to multiplier X.
REQ-009 mul_y  output  16  registered operand to multiplier Y.
REQ-010 mul_en  output  1  multiplier enable; high while a multiply is in flight.
REQ-011 prod  input  32  signed product returned by the multiplier.
REQ-012 rd_req  input  1  read request.
REQ-013 rd_sel  input  1  read select: 0 LO, 1 HI.
REQ-014 rd_data  output  16  registered read data.
REQ-015 rd_valid  output  1  rd_data valid pulse.
REQ-016 busy  output  1  multiply in flight.
REQ-017 stall  output  1  combinational: rd_req & busy.

Function
REQ-018 State machine SHALL have states IDLE, WAIT, WRITE; busy = (state != IDLE).
REQ-019 IDLE, start with op MULT/MADD: latch a->mul_x, b->mul_y, set mul_en, load counter with LAT-1, go to WAIT.
REQ-020 WAIT: decrement counter each cycle; at counter 0 go to WRITE (WAIT lasts exactly LAT cycles).
REQ-021 WRITE: {HI,LO} <= prod (MULT) or {HI,LO} + prod (MADD, 32-bit wrap, no overflow flag); clear mul_en; return to IDLE.
REQ-022 busy SHALL be high for exactly LAT+1 cycles; new HI/LO visible the cycle busy falls.
REQ-023 IDLE, start with MTHI/MTLO: HI or LO <= a at that edge; no state change; busy stays low.
REQ-024 start while busy SHALL be ignored (no operand latch, no HI/LO change).
REQ-025 rd_req while not busy: rd_data <= selected register value before any same-edge write; rd_valid high for one cycle next cycle.
REQ-026 rd_req while busy: stall high, rd_valid low; requester holds rd_req; served on first cycle busy is low.
REQ-027 Simultaneous start and rd_req in IDLE: both accepted; read returns pre-operation value.
REQ-028 mul_x/mul_y SHALL hold value after WRITE until next accepted multiply.

Reset
REQ-029 On rst: state IDLE, counter 0, HI 0, LO 0, mul_x 0, mul_y 0, mul_en 0, rd_data 0, rd_valid 0.
REQ-030 rst during WAIT/WRITE SHALL abort the multiply; no HI/LO update; busy low the cycle after reset edge.

Configuration
REQ-031 Macro HILO_MADD_EN defined: op 11 performs MADD per REQ-021.
REQ-032 Macro HILO_MADD_EN undefined: op 11 behaves exactly as MULT; no adder logic present.

Verification
REQ-033 LAT=2, HI:LO=0, MULT a=3, b=-5 -> busy high 3 cycles, then HI=0xFFFF, LO=0xFFF1.
REQ-034 MTHI a=0x1234, MTLO a=0x5678, rd_req rd_sel=1 -> next cycle rd_valid=1, rd_data=0x1234; rd_sel=0 -> 0x5678.
REQ-035 rd_req held during MULT 2*3 -> stall=1, rd_valid=0 while busy; first non-busy cycle read LO -> rd_data=0x0006 next cycle.
REQ-036 HI:LO=0x00000010, op 11 a=4, b=4 -> with HILO_MADD_EN 0x00000020; without 0x00000010.
REQ-037 MULT a=-32768, b=-32768 -> HI=0x4000, LO=0x0000; second start during busy ignored.
REQ-038 rst asserted in WAIT after MULT 7*7 with prior HI:LO=0xAAAA5555 -> HI=LO=0, busy=0, mul_en=0; no later write.
